// File: rtl/sm3_pkg.sv
// Shared SM3 constants, types and small helpers for the compression datapath.
package sm3_pkg;

  localparam logic [255:0] SM3_IV =
    256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [31:0] SM3_T0 = 32'h79cc4519;  // rounds 0..15
  localparam logic [31:0] SM3_T1 = 32'h7a879d8a;  // rounds 16..63

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin,
    StDone
  } sm3_fsm_e;

  // Working registers A..H; A lands in the top word when packed.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sm3_state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  // Round constant already rotated by j mod 32.
  function automatic logic [31:0] sm3_tj(input logic [5:0] j);
    return rotl32((j < 6'd16) ? SM3_T0 : SM3_T1, j[4:0]);
  endfunction

  function automatic logic [31:0] sm3_p0(input logic [31:0] x);
    return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
  endfunction

endpackage

// File: rtl/sm3_cmprss_ceil_comb.sv
// One combinational SM3 compression round: A..H in, updated A..H out.
module sm3_cmprss_ceil_comb
  import sm3_pkg::*;
(
  input  logic        cmprss_round_sm_16_i,
  input  logic [31:0] tj_i,
  input  logic [31:0] wj_i,
  input  logic [31:0] wjj_i,
  input  sm3_state_t  state_i,
  output sm3_state_t  state_o
);

  logic [31:0] a12, ss1, ss2, ff, gg, tt1, tt2;

  // Round function; boolean functions switch from XOR to majority/choose at j=16.
  always_comb begin
    a12 = rotl32(state_i.a, 5'd12);
    ss1 = rotl32(a12 + state_i.e + tj_i, 5'd7);
    ss2 = ss1 ^ a12;
    if (cmprss_round_sm_16_i) begin
      ff = state_i.a ^ state_i.b ^ state_i.c;
      gg = state_i.e ^ state_i.f ^ state_i.g;
    end else begin
      ff = (state_i.a & state_i.b) | (state_i.a & state_i.c) | (state_i.b & state_i.c);
      gg = (state_i.e & state_i.f) | (~state_i.e & state_i.g);
    end
    tt1 = ff + state_i.d + ss2 + wjj_i;
    tt2 = gg + state_i.h + ss1 + wj_i;
    state_o.a = tt1;
    state_o.b = state_i.a;
    state_o.c = rotl32(state_i.b, 5'd9);
    state_o.d = state_i.c;
    state_o.e = sm3_p0(tt2);
    state_o.f = state_i.e;
    state_o.g = rotl32(state_i.f, 5'd19);
    state_o.h = state_i.g;
  end

endmodule

// File: rtl/sm3_cmprss_ctrl.sv
// Sequences 64 SM3 rounds per block and holds the chaining value V between blocks.
module sm3_cmprss_ctrl
  import sm3_pkg::*;
#(
  parameter logic [255:0] IV_INIT = SM3_IV
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         blk_start_i,
  input  logic         blk_first_i,
  output logic         blk_ready_o,
  input  logic         abort_i,
  input  logic         w_valid_i,
  output logic         w_ready_o,
  input  logic [31:0]  wj_i,
  input  logic [31:0]  wjj_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [255:0] res_o,
  output logic         busy_o,
  output logic [5:0]   round_o
);

  sm3_fsm_e     state_q, state_d;
  logic [255:0] v_q, v_d;
  sm3_state_t   st_q, st_d, st_next;
  logic [5:0]   cnt_q, cnt_d;

  sm3_cmprss_ceil_comb u_ceil (
    .cmprss_round_sm_16_i (cnt_q < 6'd16),
    .tj_i                 (sm3_tj(cnt_q)),
    .wj_i                 (wj_i),
    .wjj_i                (wjj_i),
    .state_i              (st_q),
    .state_o              (st_next)
  );

  // State, chaining value, working registers and round counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      v_q     <= IV_INIT;
      st_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort overrides everything and drops any pending result.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = StIdle;
      v_d     = IV_INIT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (blk_start_i) begin
            v_d     = blk_first_i ? IV_INIT : v_q;
            st_d    = sm3_state_t'(blk_first_i ? IV_INIT : v_q);
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (w_valid_i) begin
            st_d  = st_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) state_d = StFin;
          end
        end
        StFin: begin
          v_d     = v_q ^ st_q;
          state_d = StDone;
        end
        StDone: begin
          if (res_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    blk_ready_o = (state_q == StIdle);
    w_ready_o   = (state_q == StRun);
    res_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
    round_o     = cnt_q;
    res_o       = v_q;
  end

endmodule

// File: doc/sm3_cmprss_ctrl.md
Name: sm3_cmprss_ctrl

Overview:
Sequences one SM3 compression function CF(V, B) over 64 rounds using a single instance of sm3_cmprss_ceil_comb, one round per accepted W pair. Holds the 256-bit chaining value V across blocks and produces V(i+1) = ABCDEFGH xor V(i). Sits between the message-expansion unit, which streams (Wj, W'j) pairs, and the hash top, which issues blocks and collects digests.

Parameters:
IV_INIT, 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e, initial chaining value with A in [255:224].

Ports:
clk_i  in  1  clock
rst_i  in  1  async reset, active-high
blk_start_i  in  1  request to start compression of a block
blk_first_i  in  1  sampled with blk_start_i; 1 = use IV_INIT, 0 = chain from current V
blk_ready_o  out  1  controller idle, can accept blk_start_i
abort_i  in  1  synchronous abort
w_valid_i  in  1  wj_i/wjj_i valid
w_ready_o  out  1  controller consumes a W pair this cycle if valid
wj_i  in  32  Wj for current round
wjj_i  in  32  W'j for current round
res_valid_o  out  1  res_o holds the finished V
res_ready_i  in  1  downstream accepts result
res_o  out  256  chaining value V, A in [255:224]
busy_o  out  1  state != IDLE
round_o  out  6  current round index j

Behaviour:
- Reset (async, rst_i=1): state=IDLE, V=IV_INIT, A..H=0, cnt=0. Outputs during and after reset: blk_ready_o=1, w_ready_o=0, res_valid_o=0, busy_o=0, round_o=0, res_o=IV_INIT.
- FSM states: IDLE, RUN, FIN, DONE. Outputs are decoded from the state.
  - IDLE: blk_ready_o=1. On blk_start_i: V <= blk_first_i ? IV_INIT : V; A..H <= the same selected value; cnt <= 0; go to RUN.
  - RUN: w_ready_o=1. A W pair is accepted when w_valid_i=1. On accept: A..H <= ceil outputs, cnt <= cnt+1. If cnt==63 on accept, go to FIN. When w_valid_i=0: hold everything (stall, no cycle limit).
  - FIN: one cycle. V <= V xor {A..H}; go to DONE.
  - DONE: res_valid_o=1 and res_o=V. Stay until res_ready_i=1, then go to IDLE. V is retained for chaining.
- Ceil drive:
  - cmprss_round_sm_16_i = (cnt<16).
  - tj_i = rotl32(cnt<16 ? 32'h79cc4519 : 32'h7a879d8a, cnt mod 32).
  - wj_i/wjj_i are passed straight through.
- round_o = cnt. The counter is 6 bits and never wraps in RUN, because the exit happens at 63.
- Latency:
  - start accepted at cycle 0, no stalls: last round at cycle 64, FIN at cycle 65, res_valid_o=1 from cycle 66.
  - each cycle with w_valid_i low adds one cycle.
- blk_start_i outside IDLE is ignored. res_ready_i outside DONE is ignored. W pairs are never consumed outside RUN.
- abort_i (any state, wins over every other input): go to IDLE, V <= IV_INIT, cnt <= 0, and no result is produced. An abort in DONE discards the pending result.
- Reset asserted mid-RUN: immediate return to the reset state. Partial W pairs already consumed are lost; upstream restarts.
- All arithmetic is mod 2^32 inside the ceil. The SM3_CMPRSS_DIRECT_ADD define is transparent to this block.

Decomposition:
- Package sm3_pkg holds:
  - SM3_IV and the two T base constants
  - the state enum (IDLE/RUN/FIN/DONE)
  - typedef sm3_state_t, a struct of eight 32-bit words
  - function rotl32(x, n) and function sm3_tj(j)
- Sub-module: the existing sm3_cmprss_ceil_comb, instanced once. No other sub-module.

Test Plan:
- Single block "abc" (blk_first_i=1), W/W' streamed from the GB/T 32905 expansion with w_valid_i always high -> res_valid_o rises at cycle 66; res_o = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- Two blocks of "abcd"x16 (first block blk_first_i=1, second blk_first_i=0) -> second result = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
- "abc" with w_valid_i randomly low about 50% of cycles -> same digest; round_o holds while stalled; res_valid_o arrives at 66 + number of stall cycles.
- res_ready_i held low for 10 cycles in DONE -> res_valid_o and res_o stable throughout; a blk_start_i pulse during DONE is ignored (busy_o stays 1).
- abort_i at round 30, then a new "abc" block with blk_first_i=0 -> computed from IV; correct "abc" digest.
- rst_i asserted at round 40 -> outputs go to reset values immediately, with res_o=IV_INIT; a following "abc" run gives the correct digest.
